// File: rtl/ram_loader.sv
// Boot loader: packs a little-endian byte stream into 16-bit words and writes them to RAM.
// Optional readback check enabled by defining RAM_LOADER_VERIFY_EN.
//
// state | meaning
// IDLE  | waiting for start
// LO    | accepting low byte
// HI    | accepting high byte, write cycle armed on transfer
// WRITE | RAM write cycle, checksum update
// RD    | readback cycle (verify build)
// CMP   | compare readback with written word (verify build)
// DONE  | load finished, returns to IDLE
module ram_loader #(
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [15:0]           ram_din,
  input  logic [15:0]           ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_rnw,
  output logic                  ram_cs_b,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum,
  output logic                  verify_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WRITE = 3'd3,
`ifdef RAM_LOADER_VERIFY_EN
    S_RD    = 3'd4,
    S_CMP   = 3'd5,
`endif
    S_DONE  = 3'd6
  } state_t;

  state_t              state, next_state;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [7:0]          lo_byte;
  logic                xfer;
  logic                last_word;
  logic                accept_start;
  logic                advance;

  assign xfer         = byte_valid & byte_ready;
  assign last_word    = (word_cnt == (ADDR_WIDTH+1)'(1));
  // DONE behaves like IDLE for a new start so a back-to-back start is not lost
  assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef RAM_LOADER_VERIFY_EN
  assign advance = (state == S_CMP);
`else
  assign advance = (state == S_WRITE);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept_start && (length != '0)) next_state = S_LO;
        else                                next_state = S_IDLE;
      end
      S_LO:    if (xfer) next_state = S_HI;
      S_HI:    if (xfer) next_state = S_WRITE;
`ifdef RAM_LOADER_VERIFY_EN
      S_WRITE: next_state = S_RD;
      S_RD:    next_state = S_CMP;
      S_CMP:   next_state = last_word ? S_DONE : S_LO;
`else
      S_WRITE: next_state = last_word ? S_DONE : S_LO;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready  <= 1'b0;
      ram_din     <= '0;
      ram_address <= '0;
      ram_rnw     <= 1'b1;
      ram_cs_b    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      checksum    <= '0;
      word_cnt    <= '0;
      lo_byte     <= '0;
    end else begin
      byte_ready <= (next_state == S_LO) || (next_state == S_HI);
      busy       <= !((next_state == S_IDLE) || (next_state == S_DONE));

      if (accept_start) begin
        done <= (length == '0);
        if (length != '0) begin
          checksum    <= '0;
          word_cnt    <= length;
          ram_address <= START_ADDR;
        end
      end else if (next_state == S_DONE) begin
        done <= 1'b1;
      end

      if ((state == S_LO) && xfer) lo_byte <= byte_in;

      if ((state == S_HI) && xfer) begin
        ram_din  <= {byte_in, lo_byte};
        ram_cs_b <= 1'b0;
        ram_rnw  <= 1'b0;
      end

      if (state == S_WRITE) begin
        checksum <= checksum + ram_din;
        ram_rnw  <= 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
        ram_cs_b <= 1'b0;  // chip select stays low into the readback cycle
`else
        ram_cs_b <= 1'b1;
`endif
      end

`ifdef RAM_LOADER_VERIFY_EN
      if (state == S_RD) ram_cs_b <= 1'b1;
`endif

      if (advance) begin
        ram_address <= ram_address + 1'b1;
        word_cnt    <= word_cnt - 1'b1;
      end
    end
  end

`ifdef RAM_LOADER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      verify_err <= 1'b0;
    end else if (accept_start && (length != '0)) begin
      verify_err <= 1'b0;
    end else if ((state == S_CMP) && (ram_dout != ram_din)) begin
      verify_err <= 1'b1;
    end
  end
`else
  logic unused_dout;
  assign unused_dout = ^ram_dout;
  assign verify_err  = 1'b0;
`endif

endmodule
